// File: rtl/io_pkg.sv
// Shared definitions for the CPU-bus I/O responder: register map,
// STATUS bit positions and the address decoder.
package io_pkg;

  localparam logic [15:0] ADDR_DATA   = 16'h0000;
  localparam logic [15:0] ADDR_STATUS = 16'h0001;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_AVAIL   = 2;
  localparam int ST_TX_OVERRUN = 3;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_DATA,
    SEL_STATUS
  } sel_e;

  function automatic sel_e decode(input logic [15:0] addr);
    if (addr == ADDR_DATA)        return SEL_DATA;
    else if (addr == ADDR_STATUS) return SEL_STATUS;
    else                          return SEL_NONE;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with first-word-fall-through output. Works for any
// DEPTH >= 1 (DEPTH = 1 behaves as a single holding register).
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_bar,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Empty reads as zero so the head never shows stale storage.
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_bar) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!reset_bar) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; empty-gating of dout hides its contents.
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/io_responder.sv
// CPU-bus I/O responder: address register, DATA/STATUS registers, TX byte
// FIFO toward the peripheral and RX byte buffer from it.
// Define IO_RESPONDER_RX_FIFO_EN to build RX as an RX_DEPTH-entry FIFO;
// otherwise RX is a single holding register.
module io_responder
  import io_pkg::*;
#(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_bar,
  input  logic [15:0] bus_in,
  output logic [15:0] bus_out,
  output logic        bus_oe,
  input  logic        MI,
  input  logic        DI,
  input  logic        DO,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

`ifdef IO_RESPONDER_RX_FIFO_EN
  localparam bit RX_FIFO_EN = 1'b1;
`else
  localparam bit RX_FIFO_EN = 1'b0;
`endif
  localparam int RX_FIFO_DEPTH = RX_FIFO_EN ? RX_DEPTH : 1;

  logic [15:0] addr;
  logic        tx_overrun;
  logic        ready_en;
  sel_e        sel;
  logic        rd, tx_push, tx_pop, rx_push, rx_pop, st_wr;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]  rx_head;
  logic [15:0] rd_word;

  // DI/DO act on the address held before this edge, even when MI loads a new one.
  assign sel      = decode(addr);
  assign rd       = reset_bar && DO && !DI;
  assign tx_push  = DI && (sel == SEL_DATA);
  assign st_wr    = DI && (sel == SEL_STATUS);
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_pop   = rd && (sel == SEL_DATA) && !rx_empty;
  assign rx_push  = rx_valid && rx_ready;

  assign tx_valid = !tx_empty;
  // Ready is held low until the first edge after reset releases.
  assign rx_ready = ready_en && !rx_full;
  assign bus_oe   = rd;
  assign bus_out  = rd ? rd_word : 16'h0000;

  // Address register, overrun flag and post-reset ready enable.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      addr       <= 16'h0000;
      tx_overrun <= 1'b0;
      ready_en   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (MI) addr <= bus_in;
      if (tx_push && tx_full && !tx_pop)   tx_overrun <= 1'b1;
      else if (st_wr && bus_in[ST_TX_OVERRUN]) tx_overrun <= 1'b0;
    end
  end

  // Read-data mux for the currently addressed register.
  always_comb begin
    // NOTE: default first so every path assigns rd_word and no latch is inferred.
    rd_word = 16'h0000;
    case (sel)
      SEL_DATA:   rd_word = {8'h00, rx_head};
      SEL_STATUS: begin
        rd_word[ST_TX_FULL]    = tx_full;
        rd_word[ST_TX_EMPTY]   = tx_empty;
        rd_word[ST_RX_AVAIL]   = !rx_empty;
        rd_word[ST_TX_OVERRUN] = tx_overrun;
      end
      default:    rd_word = 16'h0000;
    endcase
  end

  io_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset_bar (reset_bar),
    .push      (tx_push),
    .pop       (tx_pop),
    .din       (bus_in[7:0]),
    .dout      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  io_fifo #(.WIDTH(8), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset_bar (reset_bar),
    .push      (rx_push),
    .pop       (rx_pop),
    .din       (rx_data),
    .dout      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

endmodule

// File: tb/tb_io_responder.sv
// Scoreboarded bench for io_responder: bus reads push their expected word
// into a queue that a negedge monitor drains whenever bus_oe is high.
module tb_io_responder;

`ifdef IO_RESPONDER_RX_FIFO_EN
  localparam int RXD = 4;
`else
  localparam int RXD = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_bar = 1'b0;
  logic [15:0] bus_in = 16'h0000;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic        MI = 1'b0, DI = 1'b0, DO = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  io_responder #(.TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk       (clk),
    .reset_bar (reset_bar),
    .bus_in    (bus_in),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .MI        (MI),
    .DI        (DI),
    .DO        (DO),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each presented read against the scoreboard.
  always @(negedge clk) begin
    if (reset_bar) begin
      if (bus_oe) begin
        if (exp_q.size() == 0) check("unexpected_read", bus_out, 16'hxxxx);
        else check("bus_read", bus_out, exp_q.pop_front());
      end else if (bus_out !== 16'h0000) begin
        check("bus_out_idle", bus_out, 16'h0000);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [15:0] a);
    MI = 1'b1; bus_in = a;
    step();
    MI = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] d);
    DI = 1'b1; bus_in = d;
    step();
    DI = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] exp);
    DO = 1'b1;
    exp_q.push_back(exp);
    step();
    DO = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    check("rx_ready_before_send", 16'(rx_ready), 16'h0001);
    rx_valid = 1'b1; rx_data = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic drain_tx(input logic [7:0] first, input int n);
    tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check("drain_tx_valid", 16'(tx_valid), 16'h0001);
      check("drain_tx_data", 16'(tx_data), 16'(first + 8'(i)));
      step();
    end
    tx_ready = 1'b0;
    check("drain_tx_empty", 16'(tx_valid), 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_valid", 16'(tx_valid), 16'h0000);
    check("rst_tx_data",  16'(tx_data),  16'h0000);
    check("rst_rx_ready", 16'(rx_ready), 16'h0000);
    check("rst_bus_oe",   16'(bus_oe),   16'h0000);
    check("rst_bus_out",  bus_out,       16'h0000);
    @(negedge clk) reset_bar = 1'b1;
    #1 check("rx_ready_pre_edge", 16'(rx_ready), 16'h0000);
    step();
    check("rx_ready_first_edge", 16'(rx_ready), 16'h0001);

    // Single byte out and drained.
    set_addr(16'h0000);
    bus_write(16'h0041);
    check("tx_valid_41", 16'(tx_valid), 16'h0001);
    check("tx_data_41",  16'(tx_data),  16'h0041);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("tx_valid_popped", 16'(tx_valid), 16'h0000);

    // Undecoded address: write ignored, read zero.
    set_addr(16'h0005);
    bus_write(16'h0099);
    check("undecoded_no_push", 16'(tx_valid), 16'h0000);
    bus_read(16'h0000);
    set_addr(16'h0001);
    bus_read(16'h0002);

    // Overflow, sticky overrun, clear.
    set_addr(16'h0000);
    for (int i = 0; i < 5; i++) bus_write(16'(8'hA1 + 8'(i)));
    set_addr(16'h0001);
    bus_read(16'h0009);
    bus_write(16'h0007);
    bus_read(16'h0009);
    bus_write(16'h0008);
    bus_read(16'h0001);
    drain_tx(8'hA1, 4);

    // Push and pop together while full.
    set_addr(16'h0000);
    for (int i = 0; i < 4; i++) bus_write(16'(8'hB0 + 8'(i)));
    tx_ready = 1'b1; DI = 1'b1; bus_in = 16'h00B4;
    step();
    tx_ready = 1'b0; DI = 1'b0;
    set_addr(16'h0001);
    bus_read(16'h0001);
    drain_tx(8'hB1, 4);

    // RX path; DO in the same cycle as MI uses the old (STATUS) address.
    send_rx(8'h12);
    bus_read(16'h0006);
    MI = 1'b1; DO = 1'b1; bus_in = 16'h0000;
    exp_q.push_back(16'h0006);
    step();
    MI = 1'b0; DO = 1'b0;
    bus_read(16'h0012);
    send_rx(8'h34);
    bus_read(16'h0034);
    bus_read(16'h0000);

    // Continuous RX with no reads fills the buffer.
    acc = 0;
    rx_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rx_data = 8'h50 + 8'(k);
      if (rx_ready) acc++;
      step();
    end
    rx_valid = 1'b0;
    check("rx_accepted", 16'(acc), 16'(RXD));
    check("rx_ready_full", 16'(rx_ready), 16'h0000);
    for (int i = 0; i < RXD; i++) bus_read(16'(8'h50 + 8'(i)));
    bus_read(16'h0000);

    // DI and DO together: write only.
    send_rx(8'h77);
    DI = 1'b1; DO = 1'b1; bus_in = 16'h00C3;
    @(negedge clk);
    check("dido_bus_oe", 16'(bus_oe), 16'h0000);
    step();
    DI = 1'b0; DO = 1'b0;
    check("dido_tx_valid", 16'(tx_valid), 16'h0001);
    check("dido_tx_data",  16'(tx_data),  16'h00C3);
    bus_read(16'h0077);
    bus_read(16'h0000);
    drain_tx(8'hC3, 1);

    // Reset in the middle of traffic.
    for (int i = 0; i < 5; i++) bus_write(16'(8'hD0 + 8'(i)));
    send_rx(8'h88);
    rx_valid = 1'b1; rx_data = 8'h99;
    DO = 1'b1;
    #1 reset_bar = 1'b0;
    #1;
    check("midrst_bus_oe",   16'(bus_oe),   16'h0000);
    check("midrst_bus_out",  bus_out,       16'h0000);
    check("midrst_tx_valid", 16'(tx_valid), 16'h0000);
    check("midrst_tx_data",  16'(tx_data),  16'h0000);
    check("midrst_rx_ready", 16'(rx_ready), 16'h0000);
    @(negedge clk);
    DO = 1'b0; rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_bar = 1'b1;
    step();
    check("post_rst_tx_valid", 16'(tx_valid), 16'h0000);
    check("post_rst_rx_ready", 16'(rx_ready), 16'h0001);
    bus_read(16'h0000);
    set_addr(16'h0001);
    bus_read(16'h0002);

    step();
    check("scoreboard_empty", 16'(exp_q.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 4, TX FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter RX_DEPTH, default 4, RX FIFO entries when the RX FIFO is compiled in (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_bar  input  1  asynchronous active-low reset.
REQ-005 SHALL have port bus_in  input  16  CPU bus value.
REQ-006 SHALL have port bus_out  output  16  read data driven toward CPU bus.
REQ-007 SHALL have port bus_oe  output  1  bus_out valid / drive enable.
REQ-008 SHALL have ports MI, DI, DO  input  1 each  active-high CPU control bits: address-in, device-in (write), device-out (read).
REQ-009 SHALL have ports tx_data  output  8, tx_valid  output  1, tx_ready  input  1  byte stream toward peripheral.
REQ-010 SHALL have ports rx_data  input  8, rx_valid  input  1, rx_ready  output  1  byte stream from peripheral.

Function
REQ-011 SHALL latch bus_in into the address register on each clk edge with MI=1.
REQ-012 SHALL decode address 0x0000 as DATA and 0x0001 as STATUS; all other addresses read 0x0000 and ignore writes.
REQ-013 SHALL, when DO=1 and DI=0, assert bus_oe combinationally in the same cycle and drive bus_out from the address held before that cycle's edge.
REQ-014 SHALL return {8'h00, RX head byte} on a DATA read and pop RX at the closing edge; an empty RX returns 0x0000 with no pop.
REQ-015 SHALL return STATUS as bit0 tx_full, bit1 tx_empty, bit2 rx_avail, bit3 tx_overrun (sticky), other bits 0.
REQ-016 SHALL push bus_in[7:0] into TX on an edge with DI=1 and address DATA; a push into a full TX (with no pop in the same cycle) SHALL be dropped and set tx_overrun.
REQ-017 SHALL clear tx_overrun on a STATUS write with bus_in[3]=1; other STATUS write bits ignored.
REQ-018 SHALL, when DI=1 and DO=1 together, perform only the write, with bus_oe=0 and no RX pop.
REQ-019 SHALL use the pre-edge address for any DI/DO in the same cycle as MI=1.
REQ-020 SHALL present tx_valid = TX non-empty and tx_data = TX head; the head SHALL be popped on an edge with tx_valid and tx_ready both high.
REQ-021 SHALL drive rx_ready = RX not full and push rx_data on an edge with rx_valid and rx_ready both high.
REQ-022 SHALL, for either FIFO, allow a simultaneous push and pop when full or non-empty: both occur, count unchanged, order preserved.
REQ-023 SHALL keep bus_oe=0 and bus_out=0x0000 whenever DO=0.

Reset
REQ-024 SHALL on reset_bar=0 asynchronously clear the address to 0x0000, both FIFOs to empty, and tx_overrun to 0.
REQ-025 SHALL during reset hold tx_valid=0, rx_ready=0, bus_oe=0, bus_out=0x0000, and tx_data=0x00.
REQ-026 SHALL discard all in-flight data when reset asserts mid-transfer; rx_ready SHALL rise on the first edge after reset_bar deasserts.

Configuration
REQ-027 SHALL with IO_RESPONDER_RX_FIFO_EN defined implement RX as an RX_DEPTH-entry FIFO.
REQ-028 SHALL without IO_RESPONDER_RX_FIFO_EN implement RX as a single holding register (depth 1), with rx_ready = !rx_avail; all other behaviour is unchanged.

Structure
REQ-029 SHALL take the DATA and STATUS address constants and the STATUS bit indices from the shared package io_pkg.
REQ-030 SHALL implement both FIFOs as instances of a single sub-module io_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty).

Verification
REQ-031 Sequence MI with 0x0000, then DI with 0x0041 -> tx_valid=1 and tx_data=0x41 the next cycle; with tx_ready=1 for one cycle -> tx_valid=0.
REQ-032 With tx_ready=0, write 5 bytes to DATA -> STATUS read returns 0x0009 (full, overrun); a STATUS write of 0x0008 -> STATUS reads 0x0001.
REQ-033 Drive rx bytes 0x12, 0x34 -> STATUS bit2=1; two DATA reads return 0x0012 then 0x0034; a third returns 0x0000.
REQ-034 Feed rx bytes continuously with no reads -> rx_ready drops after 4 bytes with the macro defined, after 1 byte without it.
REQ-035 Assert DI and DO together on DATA -> bus_oe=0, one TX push, RX count unchanged; assert reset_bar=0 mid-stream -> all outputs reach reset values immediately.
